costas_gain_scheduler: RTL and testbench
========================================

# costas_gain_scheduler

Sequences the Costas loop filter through acquisition and tracking. It measures the mean magnitude of the phase-detector error over fixed windows, runs an ACQ/TRACK/LOST state machine with hysteresis, and drives the C1/C2 right-shift amounts and a lock flag. It sits beside the loop filter, takes the same 58-bit `pd_err`, and feeds the filter's coefficient-select inputs and the demodulator status logic.

## Interface
- `ACQ_MIN_CYC`, 2000: minimum cycles spent in ACQ before lock may be declared.
- `WIN_LOG2`, 8: window length is 2^WIN_LOG2 valid samples.
- `LOCK_THR`, 24'd4096: mean |err| strictly below this counts as a "good" window.
- `UNLOCK_THR`, 24'd16384: mean |err| at or above this counts as a "bad" window.
- `LOCK_WINS`, 4: consecutive good windows required to enter TRACK.
- `UNLOCK_WINS`, 2: consecutive bad windows required to leave TRACK.
- `C1_ACQ` / `C2_ACQ` / `C1_TRK` / `C2_TRK`, 35 / 38 / 38 / 41: coefficient shifts per state.
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample valid. While low, all counters and the accumulator hold.
- `restart`  in  1  synchronous single-cycle request to re-enter ACQ.
- `pd_err`  in  58  signed phase-detector error, same format as the loop filter input.
- `c1_shift`  out  6  right-shift applied to x(n)-x(n-1).
- `c2_shift`  out  6  right-shift applied to x(n-1).
- `gain_sw`  out  1  one-cycle pulse when the shift pair changes.
- `locked`  out  1  high while in TRACK.
- `state`  out  2  current state encoding.
- `err_mean`  out  24  mean |err| of the last completed window.

## Operation
- Magnitude:
  - e = pd_err[57:34], a 24-bit signed value.
  - |e| saturates to 24'h7FFFFF when e = 24'h800000.
- Window:
  - acc (24+WIN_LOG2 bits) accumulates |e| on every `en` cycle.
  - win_cnt (WIN_LOG2 bits) wraps at 2^WIN_LOG2 - 1.
  - On the wrap cycle, mean = (acc + |e|) >> WIN_LOG2; acc reloads 0 and win_end pulses.
- States:
  - ACQ = 2'd0; dwell counter counts `en` cycles, saturating at ACQ_MIN_CYC.
  - ACQ → TRACK on win_end when good_cnt reaches LOCK_WINS and dwell is saturated. A good window before dwell saturates still increments good_cnt, capped at LOCK_WINS.
  - TRACK = 2'd1: any non-bad window clears bad_cnt. TRACK → LOST on win_end when bad_cnt reaches UNLOCK_WINS.
  - LOST = 2'd2: for one cycle, clears dwell, good_cnt, bad_cnt and acc, then → ACQ.
  - In ACQ, a non-good window clears good_cnt.
  - Windows with LOCK_THR ≤ mean < UNLOCK_THR are neither good nor bad: they clear good_cnt in ACQ and bad_cnt in TRACK.
- Shift outputs:
  - ACQ/LOST → (C1_ACQ, C2_ACQ).
  - TRACK → (C1_TRK, C2_TRK).
- `restart`:
  - Forces ACQ from any state and clears dwell, counters, acc and win_cnt.
  - Takes priority over a simultaneous win_end.
  - `gain_sw` pulses only if the shift pair actually changes.
- `en` low on the wrap cycle: the window does not complete until the next `en` cycle.

## Timing
- Reset values:
  - state = ACQ, c1_shift = C1_ACQ, c2_shift = C2_ACQ.
  - locked = 0, gain_sw = 0, err_mean = 0.
  - All counters and acc are 0.
- All outputs are registered.
- `err_mean` updates 1 cycle after the last sample of a window.
- The state transition takes effect on the same edge as the `err_mean` update. Shifts, `locked` and `gain_sw` change on that edge: 1 cycle after the final window sample is presented.
- `restart` at edge k: state = ACQ and shifts at ACQ values after edge k.
- Reset asserted mid-window: the partial window is discarded and there is no `gain_sw` pulse.

## Structure
- Package `costas_pkg`:
  - state enum: ACQ = 0, TRACK = 1, LOST = 2.
  - default shift constants (35/38/38/41).
  - error slice bounds [57:34].
- Sub-module `costas_err_window`:
  - contains abs/saturate, accumulator, win_cnt and the mean output.
  - outputs win_end and mean.
  - accepts a clr input.
- Top level holds the FSM, hysteresis counters and output registers.

## Test plan
- Reset, then `en` = 1 with pd_err = 0 held:
  - TRACK is entered at the end of the first window completing at or after 2000 cycles (window 8, cycle 2048).
  - `locked` rises and `gain_sw` pulses once.
  - Shifts go 35/38 → 38/41.
- Lock, then drive e = ±20000 alternating:
  - after 2 windows, LOST for one cycle, then ACQ.
  - `locked` falls and shifts return to 35/38.
- e = 24'h800000 constant: |e| = 8388607 and `err_mean` = 8388607; no lock occurs.
- Mean alternating 3000 / 8000 per window: good_cnt never reaches 4 and the block stays in ACQ. The same pattern in TRACK never unlocks.
- `restart` in the same cycle as a qualifying win_end in ACQ: the block stays in ACQ, counters are zeroed, no `gain_sw` pulse.
- `en` toggling 1/0 during a window:
  - the window spans 256 `en` cycles (512 clocks).
  - `err_mean` matches the software model; the dwell counts only `en` cycles.

Source files
------------

// File: rtl/costas_gain_scheduler_pkg.sv
// Shared state encoding and constants for the Costas loop gain scheduler.
// Error slice bounds match the loop filter's 58-bit phase-detector word.
package costas_pkg;

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } cstate_e;

  localparam int ERR_W   = 58;
  localparam int ERR_MSB = 57;
  localparam int ERR_LSB = 34;
  localparam int MAG_W   = ERR_MSB - ERR_LSB + 1;

  localparam logic [5:0] C1_ACQ_DEF = 6'd35;
  localparam logic [5:0] C2_ACQ_DEF = 6'd38;
  localparam logic [5:0] C1_TRK_DEF = 6'd38;
  localparam logic [5:0] C2_TRK_DEF = 6'd41;

endpackage

// File: rtl/costas_gain_scheduler_if.sv
// Bundle between the scheduler and its user: sample inputs in,
// coefficient selects and lock status out.
interface costas_gain_scheduler_if;
  import costas_pkg::*;

  logic             en;
  logic             restart;
  logic [ERR_W-1:0] pd_err;
  logic [5:0]       c1_shift;
  logic [5:0]       c2_shift;
  logic             gain_sw;
  logic             locked;
  logic [1:0]       state;
  logic [MAG_W-1:0] err_mean;

  modport master (
    output en, restart, pd_err,
    input  c1_shift, c2_shift, gain_sw,
    input  locked, state, err_mean
  );

  modport slave (
    input  en, restart, pd_err,
    output c1_shift, c2_shift, gain_sw,
    output locked, state, err_mean
  );

endinterface

// File: rtl/costas_gain_scheduler_err_window.sv
// Mean |err| over fixed windows of 2^WIN_LOG2 valid samples.
// win_end_o/mean_o are combinational on the final sample of a window.
module costas_err_window
  import costas_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [ERR_W-1:0] pd_err_i,
  output logic             win_end_o,
  output logic [MAG_W-1:0] mean_o
);

  localparam int AW = MAG_W + WIN_LOG2;

  logic [MAG_W-1:0]    e;
  logic [MAG_W-1:0]    mag;
  logic [AW-1:0]       acc_q;
  logic [AW-1:0]       sum;
  logic [WIN_LOG2-1:0] cnt_q;
  logic                unused_lsbs;

  assign e = pd_err_i[ERR_MSB:ERR_LSB];
  assign unused_lsbs = ^pd_err_i[ERR_LSB-1:0];

  // Most-negative code has no positive twin: clamp it.
  always_comb begin
    mag = e;
    if (e[MAG_W-1]) begin
      if (e[MAG_W-2:0] == '0) mag = {1'b0, {(MAG_W-1){1'b1}}};
      else                    mag = ~e + 1'b1;
    end
  end

  assign sum       = acc_q + AW'(mag);
  assign mean_o    = sum[AW-1:WIN_LOG2];
  assign win_end_o = en_i & ~clr_i & (&cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= win_end_o ? '0 : sum;
    end
  end

endmodule

// File: rtl/costas_gain_scheduler.sv
// ACQ/TRACK/LOST sequencer for the Costas loop filter coefficients,
// with window-count hysteresis on mean |err| and a minimum ACQ dwell.
module costas_gain_scheduler
  import costas_pkg::*;
#(
  parameter int          ACQ_MIN_CYC = 2000,
  parameter int          WIN_LOG2    = 8,
  parameter logic [23:0] LOCK_THR    = 24'd4096,
  parameter logic [23:0] UNLOCK_THR  = 24'd16384,
  parameter int          LOCK_WINS   = 4,
  parameter int          UNLOCK_WINS = 2,
  parameter logic [5:0]  C1_ACQ      = C1_ACQ_DEF,
  parameter logic [5:0]  C2_ACQ      = C2_ACQ_DEF,
  parameter logic [5:0]  C1_TRK      = C1_TRK_DEF,
  parameter logic [5:0]  C2_TRK      = C2_TRK_DEF
) (
  input logic clk,
  input logic rst_n,
  costas_gain_scheduler_if.slave bus
);

  localparam int DW = $clog2(ACQ_MIN_CYC + 1);
  localparam int GW = $clog2(LOCK_WINS + 1);
  localparam int BW = $clog2(UNLOCK_WINS + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(ACQ_MIN_CYC);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_WINS);
  localparam logic [BW-1:0] BAD_MAX   = BW'(UNLOCK_WINS);

  cstate_e          state_q;
  logic [DW-1:0]    dwell_q;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [5:0]       c1_q, c2_q;
  logic             gsw_q, lock_q;
  logic [MAG_W-1:0] mean_q;
  logic             win_end, clr;
  logic [MAG_W-1:0] mean;

  // LOST is a one-cycle flush of the window as well as the counters.
  assign clr = bus.restart | (state_q == ST_LOST);

  costas_err_window #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (bus.en),
    .clr_i     (clr),
    .pd_err_i  (bus.pd_err),
    .win_end_o (win_end),
    .mean_o    (mean)
  );

  always_comb begin
    good_d = '0;
    bad_d  = '0;
    if (mean < LOCK_THR)
      good_d = (good_q == GOOD_MAX) ? GOOD_MAX : good_q + 1'b1;
    if (mean >= UNLOCK_THR)
      bad_d = (bad_q == BAD_MAX) ? BAD_MAX : bad_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACQ;
      dwell_q <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      c1_q    <= C1_ACQ;
      c2_q    <= C2_ACQ;
      gsw_q   <= 1'b0;
      lock_q  <= 1'b0;
      mean_q  <= '0;
    end else begin
      gsw_q <= 1'b0;
      if (win_end) mean_q <= mean;
      if (bus.restart) begin
        state_q <= ST_ACQ;
        dwell_q <= '0;
        good_q  <= '0;
        bad_q   <= '0;
        c1_q    <= C1_ACQ;
        c2_q    <= C2_ACQ;
        gsw_q   <= (c1_q != C1_ACQ) || (c2_q != C2_ACQ);
        lock_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_ACQ: begin
            if (bus.en && dwell_q != DWELL_MAX)
              dwell_q <= dwell_q + 1'b1;
            if (win_end) begin
              good_q <= good_d;
              if (good_d == GOOD_MAX && dwell_q == DWELL_MAX) begin
                state_q <= ST_TRACK;
                bad_q   <= '0;
                c1_q    <= C1_TRK;
                c2_q    <= C2_TRK;
                gsw_q   <= (c1_q != C1_TRK) || (c2_q != C2_TRK);
                lock_q  <= 1'b1;
              end
            end
          end
          ST_TRACK: begin
            if (win_end) begin
              bad_q <= bad_d;
              if (bad_d == BAD_MAX) begin
                state_q <= ST_LOST;
                c1_q    <= C1_ACQ;
                c2_q    <= C2_ACQ;
                gsw_q   <= (c1_q != C1_ACQ) || (c2_q != C2_ACQ);
                lock_q  <= 1'b0;
              end
            end
          end
          ST_LOST: begin
            state_q <= ST_ACQ;
            dwell_q <= '0;
            good_q  <= '0;
            bad_q   <= '0;
          end
          default: state_q <= ST_ACQ;
        endcase
      end
    end
  end

  assign bus.state    = state_q;
  assign bus.c1_shift = c1_q;
  assign bus.c2_shift = c2_q;
  assign bus.gain_sw  = gsw_q;
  assign bus.locked   = lock_q;
  assign bus.err_mean = mean_q;

endmodule

// File: tb/tb_costas_gain_scheduler.sv
// Scoreboard bench for costas_gain_scheduler: driver steps a window-level
// reference model and queues expected outputs; a monitor pops and compares.
module tb_costas_gain_scheduler;

  localparam int WIN         = 256;
  localparam int ACQ_MIN_CYC = 2000;
  localparam int LOCK_THR    = 4096;
  localparam int UNLOCK_THR  = 16384;
  localparam int LOCK_WINS   = 4;
  localparam int UNLOCK_WINS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  costas_gain_scheduler_if bus ();

  costas_gain_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state named by number 0=ACQ 1=TRACK 2=LOST.
  int m_state, m_dwell, m_good, m_bad, m_mean, m_wcount;
  int m_c1, m_c2;
  bit m_gsw, m_lock;
  int m_win[$];
  logic [39:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, want);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_dwell = 0; m_good = 0; m_bad = 0;
    m_mean = 0; m_wcount = 0; m_c1 = 35; m_c2 = 38;
    m_gsw = 0; m_lock = 0;
    m_win.delete();
  endfunction

  function automatic void model_step(input bit en_v, input bit rs_v,
                                     input int ev);
    int st0, p1, p2, mag;
    longint s;
    st0 = m_state; p1 = m_c1; p2 = m_c2;
    if (rs_v || m_state == 2) begin
      m_state = 0; m_dwell = 0; m_good = 0; m_bad = 0;
      m_win.delete();
    end else if (en_v) begin
      if (ev == -8388608) mag = 8388607;
      else mag = (ev < 0) ? -ev : ev;
      m_win.push_back(mag);
      if (m_win.size() == WIN) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_mean = int'(s / WIN);
        m_win.delete();
        m_wcount++;
        if (st0 == 0) begin
          if (m_mean < LOCK_THR)
            m_good = (m_good < LOCK_WINS) ? m_good + 1 : m_good;
          else m_good = 0;
          if (m_good == LOCK_WINS && m_dwell >= ACQ_MIN_CYC)
            m_state = 1;
        end else begin
          if (m_mean >= UNLOCK_THR)
            m_bad = (m_bad < UNLOCK_WINS) ? m_bad + 1 : m_bad;
          else m_bad = 0;
          if (m_bad == UNLOCK_WINS) m_state = 2;
        end
      end
      if (st0 == 0 && m_dwell < ACQ_MIN_CYC) m_dwell++;
    end
    m_c1 = (m_state == 1) ? 38 : 35;
    m_c2 = (m_state == 1) ? 41 : 38;
    m_gsw = (m_c1 != p1) || (m_c2 != p2);
    m_lock = (m_state == 1);
  endfunction

  function automatic logic [39:0] pack_exp();
    return {2'(m_state), m_lock, m_gsw, 6'(m_c1), 6'(m_c2),
            24'(m_mean)};
  endfunction

  task automatic cyc(input bit en_v, input bit rs_v, input int ev);
    logic [33:0] lo;
    @(negedge clk);
    lo = 34'({$urandom(), $urandom()});
    bus.en = en_v;
    bus.restart = rs_v;
    bus.pd_err = {24'(ev), lo};
    model_step(en_v, rs_v, ev);
    exp_q.push_back(pack_exp());
  endtask

  task automatic check_reset_vals();
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_locked", 64'(bus.locked), 64'd0);
    chk("rst_gain_sw", 64'(bus.gain_sw), 64'd0);
    chk("rst_c1", 64'(bus.c1_shift), 64'd35);
    chk("rst_c2", 64'(bus.c2_shift), 64'd38);
    chk("rst_err_mean", 64'(bus.err_mean), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.restart = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  function automatic int small_err();
    return int'($urandom_range(0, 7000)) - 3500;
  endfunction

  // Monitor: registered outputs checked #1 after each active edge.
  initial begin
    logic [39:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = {bus.state, bus.locked, bus.gain_sw,
               bus.c1_shift, bus.c2_shift, bus.err_mean};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL outputs @%0t: got st=%0d lk=%0b gs=%0b c=%0d/%0d mean=%0d want st=%0d lk=%0b gs=%0b c=%0d/%0d mean=%0d",
            $time, got[39:38], got[37], got[36], got[35:30],
            got[29:24], got[23:0], want[39:38], want[37],
            want[36], want[35:30], want[29:24], want[23:0]);
        end
      end
    end
  end

  initial begin
    bit done;
    logic [23:0] r;
    bus.en = 1'b0;
    bus.restart = 1'b0;
    bus.pd_err = '0;
    model_reset();
    do_reset();

    // Clean signal from reset: lock on window 8 (sample 2048).
    for (int i = 1; i <= 2300; i++) begin
      cyc(1'b1, 1'b0, (i > 2100) ? small_err() : 0);
      if (i == 2048) chk("pre_lock", 64'(bus.locked), 64'd0);
      if (i == 2049) begin
        chk("lock_rise", 64'(bus.locked), 64'd1);
        chk("lock_gsw", 64'(bus.gain_sw), 64'd1);
        chk("lock_c1", 64'(bus.c1_shift), 64'd38);
        chk("lock_c2", 64'(bus.c2_shift), 64'd41);
      end
      if (i == 2050) chk("gsw_single", 64'(bus.gain_sw), 64'd0);
    end

    // Large alternating error: two bad windows -> LOST -> ACQ.
    for (int i = 0; i < 600; i++)
      cyc(1'b1, 1'b0, (i % 2 == 0) ? 20000 : -20000);

    // en toggling: windows span 512 clocks, dwell counts en only.
    for (int i = 0; i < 7000 && m_state != 1; i++)
      cyc(i % 2 == 0, 1'b0, small_err());
    chk("relock_toggle", 64'(m_state), 64'd1);

    // Neutral/good alternation in TRACK: never unlocks.
    for (int i = 0; i < 6 * WIN; i++)
      cyc(1'b1, 1'b0, (m_wcount % 2 == 0) ? -8000 : 3000);
    cyc(1'b1, 1'b1, 0);
    // Same pattern in ACQ: never locks.
    for (int i = 0; i < 10 * WIN; i++)
      cyc(1'b1, 1'b0, (m_wcount % 2 == 0) ? 3000 : 8000);

    // Restart collides with the window that would declare lock.
    done = 0;
    for (int i = 0; i < 4000 && !(done && m_state == 1); i++) begin
      if (!done && m_state == 0 && m_win.size() == WIN - 1 &&
          m_dwell >= ACQ_MIN_CYC && m_good == LOCK_WINS - 1) begin
        cyc(1'b1, 1'b1, small_err());
        done = 1;
      end else begin
        cyc(1'b1, 1'b0, small_err());
      end
    end
    chk("restart_hit", 64'(done), 64'd1);

    // Reset mid-window while tracking.
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, small_err());
    do_reset();

    // Most-negative error saturates the magnitude.
    for (int i = 0; i < 3 * WIN; i++) cyc(1'b1, 1'b0, -8388608);

    // Random everything, including rare restarts.
    for (int i = 0; i < 3000; i++) begin
      r = 24'($urandom());
      if ($urandom_range(0, 3) == 0) r = 24'(small_err());
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0,
          int'($signed(r)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
